// File: rtl/ghostbus_arb2_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ghostbus_arb2_if : host request/ack pairs plus downstream ghostbus    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface ghostbus_arb2_if #(
    parameter int AW = 24,
    parameter int DW = 32
);
    logic          h0_req;
    logic          h0_we;
    logic [AW-1:0] h0_addr;
    logic [DW-1:0] h0_wdata;
    logic          h0_ack;
    logic [DW-1:0] h0_rdata;
    logic          h1_req;
    logic          h1_we;
    logic [AW-1:0] h1_addr;
    logic [DW-1:0] h1_wdata;
    logic          h1_ack;
    logic [DW-1:0] h1_rdata;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_wdata;
    logic          gb_we;
    logic          gb_re;
    logic [DW-1:0] gb_rdata;
    logic [1:0]    grant;

    // Arbiter view
    modport slave (
        input  h0_req, h0_we, h0_addr, h0_wdata,
        input  h1_req, h1_we, h1_addr, h1_wdata,
        input  gb_rdata,
        output h0_ack, h0_rdata, h1_ack, h1_rdata,
        output gb_addr, gb_wdata, gb_we, gb_re, grant
    );

    // Hosts plus downstream register tree view
    modport master (
        output h0_req, h0_we, h0_addr, h0_wdata,
        output h1_req, h1_we, h1_addr, h1_wdata,
        output gb_rdata,
        input  h0_ack, h0_rdata, h1_ack, h1_rdata,
        input  gb_addr, gb_wdata, gb_we, gb_re, grant
    );
endinterface
`default_nettype wire

// File: rtl/ghostbus_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ghostbus_arb2 : two-host arbiter serialising single-word transactions|
// | onto one fixed-latency ghostbus. GHOSTBUS_ARB_FIXED_PRIO_EN selects  |
// | fixed priority (h0 wins); default is round-robin.                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ghostbus_arb2 #(
    parameter int AW           = 24,
    parameter int DW           = 32,
    parameter int READ_LATENCY = 2
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    ghostbus_arb2_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR      = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;
    localparam logic [3:0] C_LAT     = 4'(READ_LATENCY);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    ack_q, ack_d;
    logic          gb_we_q, gb_we_d;
    logic          gb_re_q, gb_re_d;
    logic [AW-1:0] gb_addr_q, gb_addr_d;
    logic [DW-1:0] gb_wdata_q, gb_wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [1:0]    elig;
    logic          pick;

    // A host being acked this cycle cannot be granted again in the same cycle
    assign elig = {bus.h1_req & ~ack_q[1], bus.h0_req & ~ack_q[0]};

`ifdef GHOSTBUS_ARB_FIXED_PRIO_EN
    assign pick = ~elig[0];
`else
    logic last_q, last_d;

    assign pick = (&elig) ? ~last_q : elig[1];

    always_comb begin
        last_d = last_q;
        if (state_q == S_IDLE && |elig) begin
            last_d = pick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        ack_d      = 2'b00;
        gb_we_d    = 1'b0;
        gb_re_d    = 1'b0;
        gb_addr_d  = gb_addr_q;
        gb_wdata_d = gb_wdata_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        case (state_q)
            S_IDLE: begin
                if (|elig) begin
                    grant_d    = pick ? 2'b10 : 2'b01;
                    gb_addr_d  = pick ? bus.h1_addr  : bus.h0_addr;
                    gb_wdata_d = pick ? bus.h1_wdata : bus.h0_wdata;
                    if (pick ? bus.h1_we : bus.h0_we) begin
                        state_d = S_WR;
                        gb_we_d = 1'b1;
                    end else begin
                        state_d = S_RD_WAIT;
                        gb_re_d = 1'b1;
                        cnt_d   = C_LAT;
                    end
                end
            end
            S_WR: begin
                state_d = S_DONE;
                ack_d   = grant_q;
            end
            S_RD_WAIT: begin
                // Counter holds READ_LATENCY in the strobe cycle, so zero marks valid data
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    ack_d   = grant_q;
                    if (grant_q[1]) begin
                        rdata1_d = bus.gb_rdata;
                    end else begin
                        rdata0_d = bus.gb_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            grant_q    <= 2'b00;
            ack_q      <= 2'b00;
            gb_we_q    <= 1'b0;
            gb_re_q    <= 1'b0;
            gb_addr_q  <= '0;
            gb_wdata_q <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            gb_we_q    <= gb_we_d;
            gb_re_q    <= gb_re_d;
            gb_addr_q  <= gb_addr_d;
            gb_wdata_q <= gb_wdata_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign bus.h0_ack   = ack_q[0];
    assign bus.h1_ack   = ack_q[1];
    assign bus.h0_rdata = rdata0_q;
    assign bus.h1_rdata = rdata1_q;
    assign bus.gb_addr  = gb_addr_q;
    assign bus.gb_wdata = gb_wdata_q;
    assign bus.gb_we    = gb_we_q;
    assign bus.gb_re    = gb_re_q;
    assign bus.grant    = grant_q;
endmodule
`default_nettype wire

// File: tb/tb_ghostbus_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ghostbus_arb2 : cycle vectors plus reset / back-to-back sequences |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ghostbus_arb2;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int RL = 2;
`ifdef GHOSTBUS_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        logic r0; logic w0; logic [23:0] a0; logic [31:0] d0;
        logic r1; logic w1; logic [23:0] a1; logic [31:0] d1;
        logic [1:0] g; logic we; logic re; logic [23:0] ga; logic [31:0] gd;
        logic k0; logic k1; logic [31:0] rd0; logic [31:0] rd1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   tgt = -1;
    logic [31:0] tdat = '0;
    vec_t vq[$];

    ghostbus_arb2_if #(.AW(AW), .DW(DW)) bus();

    ghostbus_arb2 #(.AW(AW), .DW(DW), .READ_LATENCY(RL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Downstream model: data = addr + 0x1224, valid only in the cycle RL after gb_re
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.gb_re) begin
            tgt  <= cyc + RL;
            tdat <= {8'h00, bus.gb_addr} + 32'h1224;
        end
    end
    assign bus.gb_rdata = (cyc == tgt) ? tdat : 32'hDEADBEEF;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r0, input logic w0, input logic [23:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [23:0] a1, input logic [31:0] d1,
                       input logic [1:0] g, input logic we, input logic re, input logic [23:0] ga,
                       input logic [31:0] gd, input logic k0, input logic k1,
                       input logic [31:0] rd0, input logic [31:0] rd1);
        vq.push_back('{r0, w0, a0, d0, r1, w1, a1, d1, g, we, re, ga, gd, k0, k1, rd0, rd1});
    endtask

    task automatic drive(input vec_t v);
        bus.h0_req = v.r0; bus.h0_we = v.w0; bus.h0_addr = v.a0; bus.h0_wdata = v.d0;
        bus.h1_req = v.r1; bus.h1_we = v.w1; bus.h1_addr = v.a1; bus.h1_wdata = v.d1;
    endtask

    function automatic logic [127:0] outs();
        return 128'({bus.grant, bus.gb_we, bus.gb_re, bus.gb_addr, bus.gb_wdata,
                     bus.h0_ack, bus.h1_ack, bus.h0_rdata, bus.h1_rdata});
    endfunction

    // Strobes must stay mutually exclusive and never coincide with an ack
    always @(negedge clk) begin
        if (rst_n) begin
            chk("strobe_excl", 128'({bus.gb_we & bus.gb_re,
                                     (bus.gb_we | bus.gb_re) & (bus.h0_ack | bus.h1_ack)}), 128'd0);
        end
    end

    initial begin
        vec_t v;
        logic [23:0] pa, wa;
        logic [31:0] pd, wd;
        logic [1:0]  gw;
        logic        w, r0h, h1_seen, ack_seen;
        int          t0, last_re, re_cnt, acks;

        drive('{1'b0, 1'b0, 24'h0, 32'h0, 1'b0, 1'b0, 24'h0, 32'h0, 2'b0, 1'b0, 1'b0, 24'h0, 32'h0,
                1'b0, 1'b0, 32'h0, 32'h0});

        // Single write from h0, then single read from h1
        add(0,0,24'h00,32'h00,  0,0,24'h00,32'h00, 2'b00,0,0,24'h00,32'h00, 0,0,32'h0,32'h0);
        add(1,1,24'h40,32'hA5,  0,0,24'h00,32'h00, 2'b00,0,0,24'h00,32'h00, 0,0,32'h0,32'h0);
        add(1,1,24'h40,32'hA5,  0,0,24'h00,32'h00, 2'b01,1,0,24'h40,32'hA5, 0,0,32'h0,32'h0);
        add(1,1,24'h40,32'hA5,  0,0,24'h00,32'h00, 2'b01,0,0,24'h40,32'hA5, 1,0,32'h0,32'h0);
        add(0,0,24'h00,32'h00,  0,0,24'h00,32'h00, 2'b00,0,0,24'h40,32'hA5, 0,0,32'h0,32'h0);
        add(0,0,24'h00,32'h00,  1,0,24'h10,32'h77, 2'b00,0,0,24'h40,32'hA5, 0,0,32'h0,32'h0);
        add(0,0,24'h00,32'h00,  1,0,24'h10,32'h77, 2'b10,0,1,24'h10,32'h77, 0,0,32'h0,32'h0);
        add(0,0,24'h00,32'h00,  1,0,24'h10,32'h77, 2'b10,0,0,24'h10,32'h77, 0,0,32'h0,32'h0);
        add(0,0,24'h00,32'h00,  1,0,24'h10,32'h77, 2'b10,0,0,24'h10,32'h77, 0,0,32'h0,32'h0);
        add(0,0,24'h00,32'h00,  1,0,24'h10,32'h77, 2'b10,0,0,24'h10,32'h77, 0,1,32'h0,32'h1234);
        add(0,0,24'h00,32'h00,  0,0,24'h00,32'h00, 2'b00,0,0,24'h10,32'h77, 0,0,32'h0,32'h1234);

        // Both hosts hold write requests for four transactions
        pa = 24'h10; pd = 32'h77;
        for (int t = 0; t < 4; t++) begin
            w   = FIXED ? 1'b0 : t[0];
            r0h = FIXED ? 1'b1 : (t <= 2);
            wa  = w ? 24'h200 : 24'h100;
            wd  = w ? 32'h2222 : 32'h1111;
            gw  = w ? 2'b10 : 2'b01;
            add(r0h,1,24'h100,32'h1111, 1,1,24'h200,32'h2222, 2'b00,0,0,pa,pd, 0,0,32'h0,32'h1234);
            add(r0h,1,24'h100,32'h1111, 1,1,24'h200,32'h2222, gw,1,0,wa,wd,    0,0,32'h0,32'h1234);
            add(r0h,1,24'h100,32'h1111, 1,1,24'h200,32'h2222, gw,0,0,wa,wd,    !w,w,32'h0,32'h1234);
            pa = wa; pd = wd;
        end
        add(0,0,24'h00,32'h00, 0,0,24'h00,32'h00, 2'b00,0,0,pa,pd, 0,0,32'h0,32'h1234);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", outs(), 128'd0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            @(posedge clk);
            #1;
            v = vq[i];
            chk($sformatf("vec%0d", i), outs(),
                128'({v.g, v.we, v.re, v.ga, v.gd, v.k0, v.k1, v.rd0, v.rd1}));
            drive(v);
        end

        // h0 issues three back-to-back reads with h1 idle
        @(posedge clk);
        #1;
        bus.h0_req = 1'b1; bus.h0_we = 1'b0; bus.h0_addr = 24'h20;
        t0 = cyc; last_re = 0; re_cnt = 0; acks = 0; h1_seen = 1'b0;
        for (int k = 0; k < 60 && acks < 3; k++) begin
            @(posedge clk);
            #1;
            if (bus.h1_ack) h1_seen = 1'b1;
            if (bus.gb_re) begin
                if (re_cnt == 0) chk("rd_first_re", 128'(cyc - t0), 128'd1);
                else             chk("rd_re_spacing", 128'(cyc - last_re), 128'(3 + RL));
                last_re = cyc;
                re_cnt++;
            end
            if (bus.h0_ack) begin
                acks++;
                chk("rd_h0_rdata", 128'(bus.h0_rdata), 128'h1244);
                if (acks == 3) bus.h0_req = 1'b0;
            end
        end
        chk("rd_ack_count", 128'(acks), 128'd3);
        chk("rd_h1_quiet", 128'(h1_seen), 128'd0);

        // Reset asserted while a read waits for data
        @(posedge clk);
        #1;
        bus.h0_req = 1'b1; bus.h0_we = 1'b0; bus.h0_addr = 24'h30;
        @(posedge clk);
        #1;
        chk("rst_re_issued", 128'(bus.gb_re), 128'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", outs(), 128'd0);
        bus.h0_req = 1'b0;
        ack_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) rst_n = 1'b1;
            if (bus.h0_ack || bus.h1_ack) ack_seen = 1'b1;
        end
        chk("rst_no_ack", 128'(ack_seen), 128'd0);

        // First contention after reset goes to h0, then h1's write completes
        bus.h0_req = 1'b1; bus.h0_we = 1'b1; bus.h0_addr = 24'h60; bus.h0_wdata = 32'hBEEF;
        bus.h1_req = 1'b1; bus.h1_we = 1'b1; bus.h1_addr = 24'h55; bus.h1_wdata = 32'hCAFE;
        @(posedge clk);
        #1;
        chk("post_rst_grant", 128'(bus.grant), 128'(2'b01));
        @(posedge clk);
        #1;
        chk("post_rst_h0_ack", 128'({bus.h0_ack, bus.h1_ack}), 128'(2'b10));
        bus.h0_req = 1'b0;
        @(posedge clk);
        #1;
        chk("h1_wr_idle_gap", 128'(bus.grant), 128'd0);
        @(posedge clk);
        #1;
        chk("h1_wr_strobe", 128'({bus.grant, bus.gb_we, bus.gb_addr, bus.gb_wdata}),
            128'({2'b10, 1'b1, 24'h55, 32'hCAFE}));
        @(posedge clk);
        #1;
        chk("h1_wr_ack", 128'({bus.h1_ack, bus.h0_ack, bus.gb_we}), 128'(3'b100));
        bus.h1_req = 1'b0;
        @(posedge clk);
        #1;
        chk("h1_wr_done", 128'({bus.grant, bus.h1_ack}), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ghostbus_arb2.md
# ghostbus_arb2

Two-requester arbiter for a ghostbus host port. Two independent hosts (e.g. a serial bridge and a packet bridge) each issue single-word read/write transactions; the block serialises them onto one downstream ghostbus (address, write data, write strobe, read strobe, fixed-latency read data) feeding the auto-decoded register/RAM tree. One transaction is in flight at a time; read data is returned to the owning host with a one-cycle acknowledge.

## Interface
- AW, 24, address width
- DW, 32, data width
- READ_LATENCY, 2, cycles from the gb_re cycle to the cycle gb_rdata is valid; legal 1..15

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- hN_req  in  1  (N = 0,1) transaction request, level; held with fields stable until hN_ack
- hN_we  in  1  1 = write, 0 = read
- hN_addr  in  AW  transaction address
- hN_wdata  in  DW  write data
- hN_ack  out  1  one-cycle completion pulse
- hN_rdata  out  DW  read data, valid while hN_ack high, held afterwards
- gb_addr  out  AW  downstream address
- gb_wdata  out  DW  downstream write data
- gb_we  out  1  downstream write strobe, one cycle
- gb_re  out  1  downstream read strobe, one cycle
- gb_rdata  in  DW  downstream read data
- grant  out  2  one-hot owner of the current transaction; 0 when idle

## Operation
- States: IDLE, WR, RD_WAIT, DONE.
- IDLE: if any eligible request, latch winner's we/addr/wdata into gb_addr/gb_wdata, set grant; go WR (we=1) or RD_WAIT (we=0) with gb_re asserted for the next cycle.
- WR: gb_we high this cycle only; go DONE.
- RD_WAIT: 4-bit counter loaded with READ_LATENCY when gb_re asserted; decrements each cycle; when it reaches 0, capture gb_rdata into winner's hN_rdata; go DONE.
- DONE: hN_ack high for winner for exactly one cycle; grant cleared; go IDLE.
- Eligibility: a requester whose ack is high in the current cycle is ineligible that cycle; req still high the following cycle is a new transaction.
- Arbitration (default): round-robin. Both requesting -> grant the one not granted last. last_grant resets to 1, so h0 wins the first contention. Single requester always wins.
- Non-granted requester's hN_rdata unchanged; its ack stays low.
- gb_addr/gb_wdata hold last values between transactions.
- Fields of a requester changing while req high before grant: arbiter uses the values present in the IDLE cycle it grants.

## Timing
- Reset (async assert, sync-released internally by clk edge): state IDLE, all outputs 0 (hN_ack, hN_rdata, gb_*, grant), last_grant=1, counter 0.
- Write: req seen in IDLE cycle T -> gb_we/gb_addr/gb_wdata cycle T+1 -> hN_ack cycle T+2. Three cycles per write.
- Read: req seen in cycle T -> gb_re cycle T+1 -> gb_rdata sampled at end of cycle T+1+READ_LATENCY -> hN_ack with hN_rdata cycle T+2+READ_LATENCY.
- Back-to-back from one requester holding req: next grant earliest in cycle after ack (T+3 for writes); other requester with req pending wins that slot under round-robin.
- gb_we and gb_re never high together; never high in the same cycle as any hN_ack.
- rst_n low mid-transaction: transaction abandoned, no ack issued, all strobes drop immediately.

## Configuration
- GHOSTBUS_ARB_FIXED_PRIO_EN defined: fixed priority, h0 always wins contention; last_grant unused. h1 may starve under continuous h0 traffic.
- Undefined: round-robin as above.

## Test plan
- h0 write addr 0x40, data 0xA5 -> gb_we one cycle at T+1 with gb_addr=0x40, gb_wdata=0xA5; h0_ack at T+2; h1_ack stays 0.
- h1 read addr 0x10, READ_LATENCY=2, model returns 0x1234 -> gb_re at T+1, h1_ack and h1_rdata=0x1234 at T+4.
- h0 and h1 both request writes in same cycle, both hold req for 4 transactions -> grants alternate h0,h1,h0,h1; each ack separated by 3 cycles.
- h0 holds req for 3 reads with h1 idle -> three reads, gb_re spacing 3+READ_LATENCY cycles, no gaps beyond that.
- rst_n pulsed low during RD_WAIT -> no ack, all outputs 0 within the reset cycle; subsequent h1 write completes normally.
- With GHOSTBUS_ARB_FIXED_PRIO_EN, both requesting continuously for 4 transactions -> all four grants to h0, h1_ack never asserted.
